// File: rtl/countdown_display_encoder_if.sv
// Control and display bus between the countdown encoder and its host/display decoder.
// Defining LEADING_ZERO_BLANK_EN adds the blank signal to the display side.
interface countdown_display_encoder_if;
   logic        load;
   logic [15:0] preset;
   logic        start;
   logic        stop;
   logic        tick;
   logic        error;
   logic        clear;
   logic [3:0]  data;
   logic [3:0]  digit_sel;
   logic        running;
   logic        done;
`ifdef LEADING_ZERO_BLANK_EN
   logic        blank;

   modport master (
      output load, preset, start, stop, tick, error, clear,
      input  data, digit_sel, running, done, blank
   );
   modport slave (
      input  load, preset, start, stop, tick, error, clear,
      output data, digit_sel, running, done, blank
   );
`else
   modport master (
      output load, preset, start, stop, tick, error, clear,
      input  data, digit_sel, running, done
   );
   modport slave (
      input  load, preset, start, stop, tick, error, clear,
      output data, digit_sel, running, done
   );
`endif
endinterface

// File: rtl/countdown_display_encoder.sv
// Irrigation countdown timer: 4-digit BCD count, IDLE/RUN/ERROR control and digit scanner.
// Defining LEADING_ZERO_BLANK_EN adds a registered blank output for leading zeros.
module countdown_display_encoder #(
   parameter int unsigned SCAN_DIV = 1000
) (
   input logic                        clock,
   input logic                        reset_n,
   countdown_display_encoder_if.slave bus
);

   localparam int unsigned ScanW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {StIdle, StRun, StError} state_e;

   state_e           state_q, state_d;
   logic [15:0]      count_q, count_d;
   logic [ScanW-1:0] scan_q, scan_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       data_q, data_d;
   logic [3:0]       sel_q, sel_d;
   logic             running_q;
   logic             done_q, done_d;
`ifdef LEADING_ZERO_BLANK_EN
   logic             blank_q, blank_d;
`endif

   function automatic logic bcd_valid(input logic [15:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Decrement with borrow rippling from the least significant digit.
   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      logic [15:0] r;
      logic        borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [3:0] digit_at(input logic [15:0] v, input logic [1:0] idx);
      logic [3:0] d;
      unique case (idx)
         2'd0:    d = v[15:12];
         2'd1:    d = v[11:8];
         2'd2:    d = v[7:4];
         default: d = v[3:0];
      endcase
      return d;
   endfunction

   function automatic logic [3:0] error_char(input logic [1:0] idx);
      logic [3:0] c;
      unique case (idx)
         2'd0:    c = 4'b1011;
         2'd1:    c = 4'b1100;
         2'd2:    c = 4'b1100;
         default: c = 4'b1101;
      endcase
      return c;
   endfunction

   // Commands that have no effect in the current state are ignored and do not
   // mask lower-priority commands.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      done_d  = 1'b0;
      if (bus.error) begin
         state_d = StError;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.load) begin
                  if (bcd_valid(bus.preset)) begin
                     count_d = bus.preset;
                  end else begin
                     state_d = StError;
                  end
               end else if (bus.start && (count_q != 16'h0000)) begin
                  state_d = StRun;
               end
            end
            StRun: begin
               if (bus.stop) begin
                  state_d = StIdle;
               end else if (bus.tick) begin
                  count_d = bcd_dec(count_q);
                  if (count_d == 16'h0000) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end
               end
            end
            StError: begin
               if (bus.clear) begin
                  state_d = StIdle;
                  count_d = 16'h0000;
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_comb begin
      scan_d = scan_q + ScanW'(1);
      idx_d  = idx_q;
      if (scan_q == ScanLast) begin
         scan_d = '0;
         idx_d  = idx_q + 2'd1;
      end
   end

   // Display registers load from next-state values so data and digit_sel always agree.
   always_comb begin
      sel_d  = 4'b1000 >> idx_d;
      data_d = digit_at(count_d, idx_d);
      if (state_d == StError) begin
         data_d = error_char(idx_d);
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      blank_d = 1'b0;
      if (state_d != StError) begin
         unique case (idx_d)
            2'd0:    blank_d = (count_d[15:12] == 4'd0);
            2'd1:    blank_d = (count_d[15:8] == 8'd0);
            2'd2:    blank_d = (count_d[15:4] == 12'd0);
            default: blank_d = 1'b0;
         endcase
      end
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         count_q   <= 16'h0000;
         scan_q    <= '0;
         idx_q     <= 2'd0;
         data_q    <= 4'b0000;
         sel_q     <= 4'b1000;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         scan_q    <= scan_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         sel_q     <= sel_d;
         running_q <= (state_d == StRun);
         done_q    <= done_d;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         blank_q <= 1'b0;
      end else begin
         blank_q <= blank_d;
      end
   end

   assign bus.blank = blank_q;
`endif

   assign bus.data      = data_q;
   assign bus.digit_sel = sel_q;
   assign bus.running   = running_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_countdown_display_encoder.sv
// Randomized self-checking bench for countdown_display_encoder against an integer-count model.
// Checks blank as well when LEADING_ZERO_BLANK_EN is defined.
module tb_countdown_display_encoder;

   localparam int unsigned SCAN_DIV = 4;
   localparam int MIdle = 0;
   localparam int MRun  = 1;
   localparam int MErr  = 2;

   logic clock = 1'b0;
   logic reset_n = 1'b0;

   countdown_display_encoder_if bus ();

   countdown_display_encoder #(.SCAN_DIV(SCAN_DIV)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   // Model: decimal count, mode, edges since reset, pending done pulse.
   int m_mode  = MIdle;
   int m_count = 0;
   int m_n     = 0;
   bit m_done  = 1'b0;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int pow10(input int i);
      return (i == 0) ? 1000 : (i == 1) ? 100 : (i == 2) ? 10 : 1;
   endfunction

   function automatic bit bcd_ok(input logic [15:0] v);
      for (int i = 0; i < 4; i++) begin
         if (v[4*i +: 4] > 4'd9) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic int bcd_to_int(input logic [15:0] v);
      int r;
      r = 0;
      for (int i = 0; i < 4; i++) r += int'(v[4*(3-i) +: 4]) * pow10(i);
      return r;
   endfunction

   function automatic logic [15:0] int_to_bcd(input int c);
      logic [15:0] r;
      r = 16'h0;
      for (int i = 0; i < 4; i++) r[4*(3-i) +: 4] = 4'((c / pow10(i)) % 10);
      return r;
   endfunction

   task automatic check_outputs(input string phase);
      int         idx;
      logic [3:0] e_data;
      logic [3:0] e_sel;
      idx   = (m_n / SCAN_DIV) % 4;
      e_sel = 4'b1000 >> idx;
      if (m_mode == MErr) begin
         e_data = (idx == 0) ? 4'hB : (idx == 3) ? 4'hD : 4'hC;
      end else begin
         e_data = 4'((m_count / pow10(idx)) % 10);
      end
      check_eq({phase, ".data"}, 16'(bus.data), 16'(e_data));
      check_eq({phase, ".digit_sel"}, 16'(bus.digit_sel), 16'(e_sel));
      check_eq({phase, ".running"}, 16'(bus.running), 16'(m_mode == MRun));
      check_eq({phase, ".done"}, 16'(bus.done), 16'(m_done));
`ifdef LEADING_ZERO_BLANK_EN
      // Leading zero: every digit up to and including this one is zero.
      check_eq({phase, ".blank"}, 16'(bus.blank),
               16'((m_mode != MErr) && (idx < 3) && (m_count < pow10(idx))));
`endif
   endtask

   task automatic step(input string phase, input bit ld, input logic [15:0] pre, input bit st,
                       input bit sp, input bit tk, input bit er, input bit cl);
      int nmode;
      int ncount;
      bit ndone;
      bus.load   = ld;
      bus.preset = pre;
      bus.start  = st;
      bus.stop   = sp;
      bus.tick   = tk;
      bus.error  = er;
      bus.clear  = cl;
      nmode  = m_mode;
      ncount = m_count;
      ndone  = 1'b0;
      if (er) begin
         nmode = MErr;
      end else if (m_mode == MIdle) begin
         if (ld) begin
            if (bcd_ok(pre)) ncount = bcd_to_int(pre);
            else nmode = MErr;
         end else if (st && m_count != 0) begin
            nmode = MRun;
         end
      end else if (m_mode == MRun) begin
         if (sp) begin
            nmode = MIdle;
         end else if (tk) begin
            ncount = m_count - 1;
            if (ncount == 0) begin
               nmode = MIdle;
               ndone = 1'b1;
            end
         end
      end else if (cl) begin
         nmode  = MIdle;
         ncount = 0;
      end
      @(posedge clock);
      #1;
      m_mode  = nmode;
      m_count = ncount;
      m_done  = ndone;
      m_n++;
      bus.load  = 1'b0;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.tick  = 1'b0;
      bus.error = 1'b0;
      bus.clear = 1'b0;
      check_outputs(phase);
   endtask

   task automatic idle(input string phase, input int cycles);
      for (int i = 0; i < cycles; i++) step(phase, 0, 16'h0, 0, 0, 0, 0, 0);
   endtask

   task automatic model_reset();
      m_mode  = MIdle;
      m_count = 0;
      m_n     = 0;
      m_done  = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      model_reset();
      check_outputs("reset");
   endtask

   initial begin
      bus.load   = 1'b0;
      bus.preset = 16'h0;
      bus.start  = 1'b0;
      bus.stop   = 1'b0;
      bus.tick   = 1'b0;
      bus.error  = 1'b0;
      bus.clear  = 1'b0;

      do_reset();
      idle("scan", 17);

      step("ld12", 1, 16'h0012, 0, 0, 0, 0, 0);
      step("start12", 0, 16'h0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) begin
         step("tick12", 0, 16'h0, 0, 0, 1, 0, 0);
         idle("gap12", 1);
      end
      for (int i = 0; i < 3; i++) step("tick0", 0, 16'h0, 0, 0, 1, 0, 0);

      step("ld1000", 1, 16'h1000, 0, 0, 0, 0, 0);
      step("start1000", 0, 16'h0, 1, 0, 0, 0, 0);
      step("borrow", 0, 16'h0, 0, 0, 1, 0, 0);
      idle("borrow_scan", 16);
      step("stop999", 0, 16'h0, 0, 1, 0, 0, 0);

      step("ld50", 1, 16'h0050, 0, 0, 0, 0, 0);
      step("start50", 0, 16'h0, 1, 0, 0, 0, 0);
      idle("run50", 2);
      step("err", 0, 16'h0, 0, 0, 0, 1, 0);
      idle("err_scan", 16);
      step("err_start", 0, 16'h0, 1, 0, 1, 0, 0);
      step("err_clr_err", 0, 16'h0, 0, 0, 0, 1, 1);
      step("err_clear", 0, 16'h0, 0, 0, 0, 0, 1);
      step("zero_start", 0, 16'h0, 1, 0, 0, 0, 0);
      idle("idle0", 3);

      step("ld_bad", 1, 16'h00A0, 0, 0, 0, 0, 0);
      idle("bad_err", 2);
      step("bad_clear", 0, 16'h0, 0, 0, 0, 0, 1);

      step("ld35", 1, 16'h0035, 0, 0, 0, 0, 0);
      step("start35", 0, 16'h0, 1, 0, 0, 0, 0);
      step("tick35", 0, 16'h0, 0, 0, 1, 0, 0);
      step("stop34", 0, 16'h0, 0, 1, 0, 0, 0);
      step("held34", 0, 16'h0, 0, 0, 1, 0, 0);
      idle("held34", 8);
      step("resume", 0, 16'h0, 1, 0, 0, 0, 0);
      step("tick33", 0, 16'h0, 0, 0, 1, 0, 0);
      idle("run33", 2);

      // Asynchronous reset mid-countdown, between clock edges.
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("areset.data", 16'(bus.data), 16'h0);
      check_eq("areset.digit_sel", 16'(bus.digit_sel), 16'h8);
      check_eq("areset.running", 16'(bus.running), 16'h0);
      check_eq("areset.done", 16'(bus.done), 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
      check_eq("areset.blank", 16'(bus.blank), 16'h0);
`endif
      do_reset();

      for (int i = 0; i < 3000; i++) begin
         bit          ld, st, sp, tk, er, cl;
         logic [15:0] pre;
         ld = ($urandom_range(0, 7) == 0);
         st = ($urandom_range(0, 5) == 0);
         sp = ($urandom_range(0, 19) == 0);
         tk = ($urandom_range(0, 2) == 0);
         er = ($urandom_range(0, 59) == 0);
         cl = (m_mode == MErr) && ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) pre = 16'($urandom);
         else if ($urandom_range(0, 1) == 0) pre = int_to_bcd(int'($urandom_range(0, 40)));
         else pre = int_to_bcd(int'($urandom_range(0, 9999)));
         step("rand", ld, pre, st, sp, tk, er, cl);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/countdown_display_encoder.md
Name: countdown_display_encoder

Overview:
- Irrigation timer countdown with a 4-digit BCD count and a digit scanner.
- Produces the 4-bit character code and one-hot digit select that feed the 7-segment display decoder; the encoder side of that interface.
- Shows the running count, or the word "Erro" while in error.

Parameters:
SCAN_DIV, 1000, clock cycles each digit stays selected (>=2)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
load  input  1  load preset into count (IDLE only)
preset  input  16  4 BCD digits; [15:12] = most significant digit
start  input  1  begin countdown
stop  input  1  pause countdown (RUN -> IDLE, count held)
tick  input  1  one-cycle pulse, one per second
error  input  1  error request (external fault)
clear  input  1  leave ERROR
data  output  4  character code to display decoder
digit_sel  output  4  one-hot digit enable, active-high; bit 3 = leftmost digit
running  output  1  high in RUN
done  output  1  one-cycle pulse when count reaches 0000

Behaviour:
- Character codes: 0000-1001 digits 0-9; E=1011, r=1100, o=1101.
- Reset (async, reset_n low): state IDLE, count 0000, scan counter 0, digit index 0, digit_sel 1000, data 0000, running 0, done 0.
- States:
  - IDLE
  - RUN
  - ERROR
- Per-cycle priority: error > clear > load > stop > start > tick.
- IDLE transitions:
  - load: latch preset. If any nibble > 9, go to ERROR and leave count unchanged.
  - start with count != 0000: go to RUN.
  - start with count == 0000: ignored.
  - tick: ignored.
- RUN transitions:
  - tick: BCD decrement with borrow across digits (0100 -> 0099, 1000 -> 0999).
  - Decrement reaching 0000: done pulses high for exactly one cycle (the cycle after the tick edge), state returns to IDLE, running drops the same cycle.
  - stop: go to IDLE, count held.
  - load in RUN: ignored.
- ERROR transitions:
  - error asserted in any state: ERROR the next cycle.
  - ERROR is left only on clear with error low, going to IDLE with count 0000.
  - start, stop, load and tick are ignored in ERROR.
  - If error and clear are both high, stay in ERROR.
- running = (state == RUN), registered.
- Scanner, free-running in all states:
  - Scan counter counts 0..SCAN_DIV-1.
  - On wrap, digit index advances 0 -> 1 -> 2 -> 3 -> 0.
  - Index 0 = leftmost digit (digit_sel 1000); index 3 = digit_sel 0001.
- data and digit_sel are registered together, so they always refer to the same digit. No cycle exists where digit_sel shows the new digit while data is still old.
- data content:
  - Outside ERROR: count nibble for the current index.
  - In ERROR: index 0..3 gives 1011, 1100, 1100, 1101.
- A count change mid-slot is reflected on data the next cycle without disturbing scan timing.
- reset_n asserted mid-countdown or mid-scan: all outputs return to reset values immediately (asynchronous); the pending done pulse is discarded.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Adds output port blank (1 bit), registered alongside data.
  - blank is high while the selected digit is a leading zero: every digit to its left, and itself, is 0.
  - Index 3 is never blanked, so 0000 shows "0".
  - blank is 0 in ERROR; reset value 0.
  - data is unchanged by blanking.
- Undefined: no blank port; every digit is always displayed.

Test Plan:
- Reset, SCAN_DIV=4: release reset_n; digit_sel steps 1000 -> 0100 -> 0010 -> 0001 -> 1000, one step every 4 cycles; data=0000, running=0, done=0.
- load preset 0012, start, 12 ticks: count steps 0011 ... 0000; done pulses 1 cycle after the 12th tick; running=0 afterwards; further ticks leave count 0000.
- Borrow: load 1000, start, 1 tick -> count 0999; scan shows data 0,9,9,9 at digit_sel 1000,0100,0010,0001.
- Error mid-run at count 0050: scan shows 1011,1100,1100,1101; start and tick ignored; clear plus error together keeps ERROR; clear alone -> IDLE, count 0000.
- Invalid preset 00A0 with load -> ERROR the next cycle. Start with count 0000 -> stays IDLE, running=0. stop during RUN at 0034 -> IDLE, count held at 0034; start resumes.
- LEADING_ZERO_BLANK_EN defined, count 0050: blank=1,1,0,0 per index. Count 0000: blank=1,1,1,0. Asynchronous reset asserted mid-RUN: all outputs return to reset values before the next clock edge.
